// File: rtl/coproc_pkg.sv
// Shared definitions for the zoom coprocessor command interface: opcodes,
// issuer state encoding and response status layout.
package coproc_pkg;

  // Both ends of the interface import this table.
  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_LOAD         = 3'd1;
  localparam logic [2:0] OP_STORE        = 3'd2;
  localparam logic [2:0] OP_ZOOM_IN_VP   = 3'd3;
  localparam logic [2:0] OP_ZOOM_OUT_VP  = 3'd4;
  localparam logic [2:0] OP_ZOOM_IN_AVG  = 3'd5;
  localparam logic [2:0] OP_ZOOM_OUT_DEC = 3'd6;
  localparam logic [2:0] OP_RESET_INST   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_RESPOND
  } state_e;

  localparam int RSP_TIMEOUT  = 3;
  localparam int RSP_ERROR    = 2;
  localparam int RSP_ZOOM_MAX = 1;
  localparam int RSP_ZOOM_MIN = 0;

  localparam int CNT_W  = 21;
  localparam int SYNC_W = 12;

  function automatic logic [3:0] pack_status(input logic timeout, input logic err,
                                             input logic zmax, input logic zmin);
    logic [3:0] s;
    s               = '0;
    s[RSP_TIMEOUT]  = timeout;
    s[RSP_ERROR]    = err;
    s[RSP_ZOOM_MAX] = zmax;
    s[RSP_ZOOM_MIN] = zmin;
    return s;
  endfunction

endpackage

// File: rtl/flag_sync.sv
// Multi-bit, multi-stage synchronizer for the coprocessor status outputs.
// Each bit is synchronized independently; RESET_VAL sets the idle-safe value.
module flag_sync #(
  parameter int              WIDTH     = 12,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // NOTE: every stage is reset; this is a flop chain, not a RAM, so the loop costs nothing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/coproc_cmd_issuer.sv
// Initiator side of the zoom coprocessor command interface: accepts one host
// command, strobes ENABLE, tracks FLAG_DONE and returns one response beat.
module coproc_cmd_issuer
  import coproc_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int DONE_TIMEOUT = 1048576,
  parameter int RESET_SETTLE = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_instr,
  input  logic [16:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_status,
  output logic [2:0]  INSTRUCTION,
  output logic [16:0] MEM_ADDR,
  output logic [7:0]  DATA_IN,
  output logic        ENABLE,
  input  logic [7:0]  DATA_OUT,
  input  logic        FLAG_DONE,
  input  logic        FLAG_ERROR,
  input  logic        FLAG_ZOOM_MAX,
  input  logic        FLAG_ZOOM_MIN
);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ack_seen;
  logic               r_cmd_ready, r_rsp_valid, r_enable;
  logic [7:0]         r_rsp_data;
  logic [3:0]         r_rsp_status;
  logic [2:0]         r_instr;
  logic [16:0]        r_addr;
  logic [7:0]         r_din;

  logic [SYNC_W-1:0]  w_sync;
  logic [7:0]         w_dout;
  logic               w_done, w_err, w_zmax, w_zmin;
  logic               w_accept, w_capture, w_ack_to, w_done_to, w_cnt_clr;

  // FLAG_DONE resets to its idle (high) level so nothing downstream sees a false busy.
  flag_sync #(
    .WIDTH    (SYNC_W),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(SYNC_W'(12'h008))
  ) u_flag_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    ({DATA_OUT, FLAG_DONE, FLAG_ERROR, FLAG_ZOOM_MAX, FLAG_ZOOM_MIN}),
    .o_q    (w_sync)
  );

  assign w_dout = w_sync[11:4];
  assign w_done = w_sync[3];
  assign w_err  = w_sync[2];
  assign w_zmax = w_sync[1];
  assign w_zmin = w_sync[0];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_ack_to    = 1'b0;
    w_done_to   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = (cmd_instr == OP_NOP) ? ST_RESPOND : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt >= CNT_W'(SETUP_CYCLES - 1)) begin
          w_state_nxt = ST_PULSE;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_PULSE: begin
        // The ack timeout counts from the first ENABLE-low cycle, so the counter runs on.
        if (r_cnt >= CNT_W'(PULSE_CYCLES - 1)) begin
          if (r_instr == OP_RESET_INST) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (r_ack_seen || !w_done) begin
          w_state_nxt = ST_WAIT_DONE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt >= CNT_W'(ACK_TIMEOUT - 1)) begin
          w_ack_to    = 1'b1;
          w_state_nxt = ST_RESPOND;
        end
      end
      ST_WAIT_DONE: begin
        if (w_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESPOND;
        end else if (r_cnt >= CNT_W'(DONE_TIMEOUT - 1)) begin
          w_done_to   = 1'b1;
          w_state_nxt = ST_RESPOND;
        end
      end
      ST_SETTLE: begin
        if (r_cnt >= CNT_W'(RESET_SETTLE - 1)) w_state_nxt = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ack_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr)            r_cnt <= '0;
      else if (r_cnt != '1)     r_cnt <= r_cnt + CNT_W'(1);
      // A one-cycle low glitch during the pulse must still count as the ack.
      if (w_accept)             r_ack_seen <= 1'b0;
      else if ((r_state == ST_PULSE || r_state == ST_WAIT_ACK) && !w_done)
                                r_ack_seen <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_enable     <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_instr      <= OP_NOP;
      r_addr       <= '0;
      r_din        <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESPOND);
      r_enable    <= (w_state_nxt != ST_PULSE);
      if (w_accept) begin
        r_instr      <= cmd_instr;
        r_addr       <= cmd_addr;
        r_din        <= cmd_data;
        r_rsp_data   <= '0;
        r_rsp_status <= '0;
      end
      if (w_capture) begin
        r_rsp_data   <= (r_instr == OP_LOAD) ? w_dout : 8'h00;
        r_rsp_status <= pack_status(1'b0, w_err, w_zmax, w_zmin);
      end
      if (w_done_to) r_rsp_status <= pack_status(1'b1, w_err, w_zmax, w_zmin);
      if (w_ack_to)  r_rsp_status <= pack_status(1'b1, 1'b0, 1'b0, 1'b0);
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_status  = r_rsp_status;
  assign INSTRUCTION = r_instr;
  assign MEM_ADDR    = r_addr;
  assign DATA_IN     = r_din;
  assign ENABLE      = r_enable;

endmodule
